lfsr_rng_stream: RTL and testbench

Parametrised Fibonacci-LFSR random-number generator with runtime seed loading, zero-seed protection and a valid/ready output stream. It is the next-generation replacement for the fixed 64-bit generator feeding the top-level IO pins. LFSR length, feedback taps, reset seed and output word width are all generic. A word is assembled from successive feedback bits and is held under backpressure without losing or repeating data.

---
 rtl/lfsr_rng_stream.sv | 92 +++++++++
 tb/tb_lfsr_rng_stream.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_stream.sv
// Fibonacci-LFSR random-number generator with runtime seeding, zero-seed
// protection and a valid/ready word stream that holds data under backpressure.
`timescale 1ns/1ps

module lfsr_rng_stream #(
  parameter int unsigned         LFSR_W = 64,
  parameter int unsigned         OUT_W  = 16,
  parameter logic [LFSR_W-1:0]   TAPS   = LFSR_W'(64'hD800_0000_0000_0000),
  parameter logic [LFSR_W-1:0]   SEED   = LFSR_W'(64'h1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic [OUT_W-1:0]  rnd_number,
  output logic              seed_fixed
);

  localparam int unsigned      CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(OUT_W - 1);

  if (LFSR_W < 2) begin : g_bad_lfsr_w
    $error("lfsr_rng_stream: LFSR_W must be at least 2");
  end
  if (OUT_W < 2 || OUT_W > 64) begin : g_bad_out_w
    $error("lfsr_rng_stream: OUT_W must be in 2..64");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_rng_stream: SEED must be nonzero");
  end

  logic [LFSR_W-1:0] state;
  logic [OUT_W-2:0]  col;
  logic [CNT_W-1:0]  cnt;
  logic [OUT_W-1:0]  col_next;
  logic              fb;
  logic              last;
  logic              stall;
  logic              step;
  logic              done;
  logic              take;
  logic              seed_zero;

  assign fb        = ^(state & TAPS);
  // The collector only keeps OUT_W-1 bits: the newest bit goes straight
  // into the output word on the completing step.
  assign col_next  = {col, fb};
  assign last      = (cnt == LAST);
  assign stall     = last && rnd_valid && !rnd_ready;
  assign step      = en && !seed_load && !stall;
  assign done      = step && last;
  assign take      = rnd_valid && rnd_ready;
  assign seed_zero = (seed_in == '0);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEED;
      col        <= '0;
      cnt        <= '0;
      rnd_valid  <= 1'b0;
      rnd_number <= '0;
      seed_fixed <= 1'b0;
    end else if (seed_load) begin
      // A pending word is dropped; rnd_number keeps its last value.
      state      <= seed_zero ? SEED : seed_in;
      seed_fixed <= seed_zero;
      col        <= '0;
      cnt        <= '0;
      rnd_valid  <= 1'b0;
    end else begin
      if (step) begin
        state <= {state[LFSR_W-2:0], fb};
        col   <= col_next[OUT_W-2:0];
        cnt   <= last ? '0 : cnt + CNT_W'(1);
      end
      // A completing step overrides the handshake so back-to-back words
      // keep rnd_valid high without a bubble.
      if (done) begin
        rnd_number <= col_next;
        rnd_valid  <= 1'b1;
      end else if (take) begin
        rnd_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rng_stream.sv
// Directed bench for lfsr_rng_stream: an 8-bit instance for reset, latency and
// full-period checks, and a default 64/16 instance for stream-protocol checks.
`timescale 1ns/1ps

module tb_lfsr_rng_stream;

  localparam logic [7:0]  TAPS_A = 8'hB8;
  localparam logic [63:0] TAPS_B = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SEED_P = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SEED_R = 64'hDEAD_BEEF_0123_4567;

  logic        clk;
  logic        rst_n;

  logic        a_en, a_load, a_ready, a_valid, a_fixed;
  logic [7:0]  a_seed, a_num;

  logic        b_en, b_load, b_ready, b_valid, b_fixed;
  logic [63:0] b_seed;
  logic [15:0] b_num;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  ma;
  logic [63:0] mb;

  lfsr_rng_stream #(
    .LFSR_W(8), .OUT_W(8), .TAPS(8'hB8), .SEED(8'h01)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .seed_load(a_load), .seed_in(a_seed),
    .rnd_valid(a_valid), .rnd_ready(a_ready), .rnd_number(a_num), .seed_fixed(a_fixed)
  );

  lfsr_rng_stream dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .seed_load(b_load), .seed_in(b_seed),
    .rnd_valid(b_valid), .rnd_ready(b_ready), .rnd_number(b_num), .seed_fixed(b_fixed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference LFSR: shift left, XOR of tapped bits enters at bit 0. The last
  // OUT_W feedback bits of a word end up in the low OUT_W state bits.
  function automatic logic [7:0] adv_a(input logic [7:0] s, input int n);
    logic [7:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = {r[6:0], ^(r & TAPS_A)};
    return r;
  endfunction

  function automatic logic [63:0] adv_b(input logic [63:0] s, input int n);
    logic [63:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = {r[62:0], ^(r & TAPS_B)};
    return r;
  endfunction

  // NOTE: inputs change 1 ns after the rising edge and outputs are sampled
  // there too, keeping both away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid_a(output int c);
    c = 0;
    while (!a_valid && c < 64) begin
      tick();
      c++;
    end
    if (!a_valid) check("a_wait_valid", 64'(a_valid), 64'(1));
  endtask

  task automatic wait_valid_b(output int c);
    c = 0;
    while (!b_valid && c < 64) begin
      tick();
      c++;
    end
    if (!b_valid) check("b_wait_valid", 64'(b_valid), 64'(1));
  endtask

  // Seed 8'h01: feedback bits 0,0,0,1,1,1,0,0 give the first word 8'h1C after 8 steps.
  task automatic first_word_a(input string tag);
    repeat (7) tick();
    check({tag, "_pre"}, 64'(a_valid), 64'(0));
    tick();
    check({tag, "_valid"}, 64'(a_valid), 64'(1));
    check({tag, "_word"}, 64'(a_num), 64'h1C);
  endtask

  // Consumes n words on dut_b (rnd_ready must be high), comparing each to the model.
  task automatic take_words_b(input int n, input string tag);
    int c;
    for (int i = 0; i < n; i++) begin
      wait_valid_b(c);
      mb = adv_b(mb, 16);
      check(tag, 64'(b_num), 64'(mb[15:0]));
      tick();
    end
  endtask

  initial begin
    int          c;
    int          nd;
    int          gap_bad;
    int          bad;
    int          nwords;
    bit          seen [256];
    logic [15:0] pend;
    logic [15:0] pn;
    logic [63:0] tmp;
    logic        pv;

    rst_n  = 1'b0;
    a_en   = 1'b0; a_load = 1'b0; a_ready = 1'b0; a_seed = '0;
    b_en   = 1'b0; b_load = 1'b0; b_ready = 1'b0; b_seed = '0;
    #22;
    check("a_rst_valid", 64'(a_valid), 64'(0));
    check("a_rst_num",   64'(a_num),   64'(0));
    check("a_rst_fixed", 64'(a_fixed), 64'(0));
    check("b_rst_valid", 64'(b_valid), 64'(0));
    check("b_rst_num",   64'(b_num),   64'(0));
    check("b_rst_fixed", 64'(b_fixed), 64'(0));

    // 8-bit latency and first word
    rst_n   = 1'b1;
    a_en    = 1'b1;
    a_ready = 1'b1;
    first_word_a("a_first");

    // Full period: 255 distinct nonzero words, word 256 wraps to word 1
    ma = 8'h01;
    nd = 0;
    gap_bad = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      wait_valid_a(c);
      if (k > 1 && c != 7) gap_bad++;
      ma = adv_a(ma, 8);
      check("a_period_word", 64'(a_num), 64'(ma));
      if (k <= 255) begin
        if (a_num != 8'h00 && !seen[a_num]) nd++;
        seen[a_num] = 1'b1;
      end
      if (k == 256) check("a_wrap", 64'(a_num), 64'h1C);
      tick();
    end
    check("a_gap", 64'(gap_bad), 64'(0));
    check("a_distinct", 64'(nd), 64'(255));

    // Zero seed on the 8-bit instance restarts the post-reset stream
    a_load = 1'b1;
    a_seed = 8'h00;
    tick();
    a_load = 1'b0;
    check("a_zs_fixed", 64'(a_fixed), 64'(1));
    check("a_zs_valid", 64'(a_valid), 64'(0));
    check("a_zs_keep",  64'(a_num),   64'h1C);
    first_word_a("a_zs");

    // Asynchronous reset in the middle of a clock-high phase
    a_ready = 1'b0;
    repeat (3) tick();
    check("a_pre_rst_valid", 64'(a_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("a_arst_valid", 64'(a_valid), 64'(0));
    check("a_arst_num",   64'(a_num),   64'(0));
    check("a_arst_fixed", 64'(a_fixed), 64'(0));
    #3 rst_n = 1'b1;
    a_ready = 1'b1;
    first_word_a("a_rerst");
    a_en = 1'b0;

    // Default instance: post-reset stream from SEED = 1
    b_en    = 1'b1;
    b_ready = 1'b1;
    mb      = 64'h1;
    wait_valid_b(c);
    check("b_latency", 64'(c), 64'(16));
    take_words_b(5, "b_reset_word");

    // Backpressure: the word holds, the LFSR parks at the last bit
    b_load  = 1'b1;
    b_seed  = SEED_P;
    tick();
    b_load  = 1'b0;
    b_ready = 1'b0;
    mb      = SEED_P;
    wait_valid_b(c);
    check("b_bp_latency", 64'(c), 64'(16));
    mb = adv_b(mb, 16);
    check("b_bp_first", 64'(b_num), 64'(mb[15:0]));
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (b_valid !== 1'b1 || b_num !== mb[15:0]) bad++;
    end
    check("b_bp_hold", 64'(bad), 64'(0));
    b_ready = 1'b1;
    tick();
    tmp = adv_b(mb, 16);
    check("b_bp_next_valid", 64'(b_valid), 64'(1));
    check("b_bp_next_word",  64'(b_num),   64'(tmp[15:0]));
    take_words_b(3, "b_bp_word");

    // Zero seed load: SEED substituted, stream restarts as after reset
    b_load = 1'b1;
    b_seed = 64'h0;
    tick();
    b_load = 1'b0;
    check("b_zs_fixed", 64'(b_fixed), 64'(1));
    check("b_zs_valid", 64'(b_valid), 64'(0));
    check("b_zs_keep",  64'(b_num),   64'(mb[15:0]));
    mb = 64'h1;
    take_words_b(4, "b_zs_word");

    // Reload at cnt = 7 while a word is pending and being accepted
    b_ready = 1'b0;
    wait_valid_b(c);
    mb   = adv_b(mb, 16);
    pend = mb[15:0];
    check("b_rl_pending", 64'(b_num), 64'(pend));
    repeat (7) tick();
    check("b_rl_still_valid", 64'(b_valid), 64'(1));
    b_ready = 1'b1;
    b_load  = 1'b1;
    b_seed  = SEED_R;
    tick();
    b_load  = 1'b0;
    check("b_rl_valid", 64'(b_valid), 64'(0));
    check("b_rl_fixed", 64'(b_fixed), 64'(0));
    check("b_rl_keep",  64'(b_num),   64'(pend));
    mb = SEED_R;
    repeat (15) tick();
    check("b_rl_pre", 64'(b_valid), 64'(0));
    tick();
    check("b_rl_at16", 64'(b_valid), 64'(1));
    take_words_b(2, "b_rl_word");

    // Random en / rnd_ready: stream follows the model, held words never change
    nwords = 0;
    for (int i = 0; i < 800; i++) begin
      b_en    = ($urandom_range(3, 0) != 0);
      b_ready = $urandom_range(1, 0) == 1;
      if (b_valid && b_ready) begin
        mb = adv_b(mb, 16);
        check("b_rand_word", 64'(b_num), 64'(mb[15:0]));
        nwords++;
      end
      pv = b_valid && !b_ready;
      pn = b_num;
      tick();
      if (pv) begin
        check("b_rand_hold_valid", 64'(b_valid), 64'(1));
        check("b_rand_hold_word",  64'(b_num),   64'(pn));
      end
    end
    check("b_rand_progress", 64'(nwords >= 5), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
